// File: rtl/nios2_sopc_nios2_0_cpu_mul_seq.sv
// Multi-cycle multiply sequencer for the Nios II execute path.
// Drives operands into a three-partial-product multiplier cell and assembles
// either the low word (mul) or the high word (mulxuu/mulxsu/mulxss) of the
// 64-bit product from the cell's registered 16x16 partial products.
// Optional feature macro: NIOS2_MUL_SEQ_SIGNED_EN enables the signed
// corrections for mulxsu/mulxss; without it those ops return the unsigned
// high word.
module nios2_sopc_nios2_0_cpu_mul_seq #(
   parameter int SKIP_HI = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_LO,
      CAP_LO,
      CAP_HI,
      DONE
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [1:0]  op_reg;
   logic [63:0] acc;
   logic [31:0] result_reg;
   logic        done_reg;

   logic        need_hi;
   logic        accept;
   logic [32:0] mid_sum;
   logic [63:0] acc_next;
   logic [31:0] hi_raw;
   logic [31:0] hi_word;

   // Only a plain mul with the skip option enabled can finish after the low pass.
   assign need_hi = (op_reg != 2'b00) || (SKIP_HI == 0);
   assign accept  = ((state == IDLE) || (state == DONE)) && start && !flush;

   // Low-pass accumulation; the cross terms are summed in 33 bits so no carry is lost.
   assign mid_sum  = {1'b0, cell_p2} + {1'b0, cell_p3};
   assign acc_next = {32'h0, cell_p1} + ({31'h0, mid_sum} << 16);
   assign hi_raw   = acc[63:32] + cell_p1;

`ifdef NIOS2_MUL_SEQ_SIGNED_EN
   logic [31:0] corr_b;
   logic [31:0] corr_a;

   // Two's-complement fix-ups turning the unsigned high word into a signed one.
   always_comb begin
      corr_b = 32'h0;
      corr_a = 32'h0;
      if (op_reg[1] && a_reg[31]) corr_b = b_reg;
      if ((op_reg == 2'b11) && b_reg[31]) corr_a = a_reg;
      hi_word = hi_raw - corr_b - corr_a;
   end
`else
   assign hi_word = hi_raw;
`endif

   // Next-state selection; flush overrides everything including a new start.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: next_state = start ? ISSUE_LO : IDLE;
         ISSUE_LO:   next_state = CAP_LO;
         CAP_LO:     next_state = need_hi ? CAP_HI : DONE;
         CAP_HI:     next_state = DONE;
         default:    next_state = IDLE;
      endcase
      if (flush) next_state = IDLE;
   end

   // Cell operand and enable drive, decoded purely from the current state.
   always_comb begin
      cell_en   = 1'b0;
      cell_src1 = 32'h0;
      cell_src2 = 32'h0;
      case (state)
         ISSUE_LO: begin
            cell_en   = 1'b1;
            cell_src1 = a_reg;
            cell_src2 = b_reg;
         end
         CAP_LO: begin
            if (need_hi) begin
               cell_en   = 1'b1;
               cell_src1 = {16'h0, a_reg[31:16]};
               cell_src2 = {16'h0, b_reg[31:16]};
            end
         end
         default: begin
            cell_en = 1'b0;
         end
      endcase
   end

   // State register, operand latches, accumulator, result and done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         a_reg      <= 32'h0;
         b_reg      <= 32'h0;
         op_reg     <= 2'b00;
         acc        <= 64'h0;
         result_reg <= 32'h0;
         done_reg   <= 1'b0;
      end else begin
         state    <= next_state;
         done_reg <= (next_state == DONE);
         if (accept) begin
            a_reg  <= src1;
            b_reg  <= src2;
            op_reg <= op;
         end
         if (state == CAP_LO) acc <= acc_next;
         if (!flush) begin
            if ((state == CAP_LO) && !need_hi) result_reg <= acc_next[31:0];
            if (state == CAP_HI) result_reg <= (op_reg == 2'b00) ? acc[31:0] : hi_word;
         end
      end
   end

   assign busy   = (state == ISSUE_LO) || (state == CAP_LO) || (state == CAP_HI);
   assign done   = done_reg;
   assign result = result_reg;

endmodule

// File: tb/tb_nios2_sopc_nios2_0_cpu_mul_seq.sv
// Self-checking bench for the multiply sequencer: models the multiplier cell,
// compares every result against a 64-bit arithmetic reference and checks
// latency, result hold, busy-ignore, flush and asynchronous reset behaviour.
module tb_nios2_sopc_nios2_0_cpu_mul_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] cell_src1;
   logic [31:0] cell_src2;
   logic        cell_en;
   logic [31:0] cell_p1;
   logic [31:0] cell_p2;
   logic [31:0] cell_p3;

   int          checkCount = 0;
   int          errorCount = 0;
   logic [31:0] lastResult = 32'h0;

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   nios2_sopc_nios2_0_cpu_mul_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .cell_src1 (cell_src1),
      .cell_src2 (cell_src2),
      .cell_en   (cell_en),
      .cell_p1   (cell_p1),
      .cell_p2   (cell_p2),
      .cell_p3   (cell_p3)
   );

   // Behavioural multiplier cell: registered 16x16 partial products, cleared by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cell_p1 <= 32'h0;
         cell_p2 <= 32'h0;
         cell_p3 <= 32'h0;
      end else if (cell_en) begin
         cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
         cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
         cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
      end
   end

   // Safety net so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Reference: full 64-bit product with operands extended per op, then word select.
   function automatic logic [31:0] refModel(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] prod;
      ea = {32'h0, a};
      eb = {32'h0, b};
`ifdef NIOS2_MUL_SEQ_SIGNED_EN
      if (opIn[1]) ea = {{32{a[31]}}, a};
      if (opIn == 2'b11) eb = {{32{b[31]}}, b};
`endif
      prod = ea * eb;
      return (opIn == 2'b00) ? prod[31:0] : prod[63:32];
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Issues one op in the current cycle and waits (bounded) for its done pulse.
   task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expected, input bit pokeStart);
      int latency;
      int cyc;
      bit seen;
      latency = (opIn == 2'b00) ? 3 : 4;
      start = 1'b1;
      op    = opIn;
      src1  = a;
      src2  = b;
      seen  = 1'b0;
      cyc   = 0;
      while (!seen && cyc < 10) begin
         stepCycle();
         cyc++;
         start = 1'b0;
         op    = 2'($urandom);
         src1  = $urandom;
         src2  = $urandom;
         if (pokeStart && (cyc == 1 || cyc == 2)) start = 1'b1;
         if (cyc == 1) begin
            checkOutput("busy_issue", 32'(busy), 32'h1);
            checkOutput("cell_en_issue", 32'(cell_en), 32'h1);
            checkOutput("cell_src1_issue", cell_src1, a);
            checkOutput("cell_src2_issue", cell_src2, b);
         end
         if (done) begin
            seen = 1'b1;
            checkOutput("latency", 32'(cyc), 32'(latency));
            checkOutput("result", result, expected);
            checkOutput("busy_done", 32'(busy), 32'h0);
            lastResult = expected;
         end else begin
            checkOutput("result_held", result, lastResult);
         end
      end
      if (!seen) checkOutput("done_timeout", 32'h0, 32'h1);
      start = 1'b0;
   endtask

   // Idle cycles with no request; done must stay low and result must hold.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         stepCycle();
         checkOutput("idle_done", 32'(done), 32'h0);
         checkOutput("idle_result", result, lastResult);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "_done"}, 32'(done), 32'h0);
      checkOutput({tag, "_result"}, result, 32'h0);
      checkOutput({tag, "_cell_en"}, 32'(cell_en), 32'h0);
      checkOutput({tag, "_cell_src1"}, cell_src1, 32'h0);
      checkOutput({tag, "_cell_src2"}, cell_src2, 32'h0);
   endtask

   // Main sequence: reset, directed vectors, hazards, then randomized ops.
   initial begin
      logic [1:0]  rOp;
      logic [31:0] rA;
      logic [31:0] rB;
      reset_n = 1'b0;
      start   = 1'b0;
      flush   = 1'b0;
      op      = 2'b00;
      src1    = 32'h0;
      src2    = 32'h0;
      stepCycle();
      stepCycle();
      checkAllZero("reset");
      reset_n = 1'b1;
      stepCycle();

      applyStimulus(2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 1'b0);
      idleCycles(1);
      applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      idleCycles(1);
      applyStimulus(2'b01, 32'h00010003, 32'h00020005, 32'h00000002, 1'b1);
      idleCycles(2);
`ifdef NIOS2_MUL_SEQ_SIGNED_EN
      applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
      idleCycles(1);
      applyStimulus(2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b1);
`else
      applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      idleCycles(1);
      applyStimulus(2'b10, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b1);
`endif
      idleCycles(1);

      // Back-to-back: the second start lands in the first op's done cycle.
      applyStimulus(2'b00, 32'h12345678, 32'h9ABCDEF0, refModel(2'b00, 32'h12345678, 32'h9ABCDEF0), 1'b0);
      applyStimulus(2'b01, 32'h12345678, 32'h9ABCDEF0, refModel(2'b01, 32'h12345678, 32'h9ABCDEF0), 1'b0);
      applyStimulus(2'b11, 32'h80000000, 32'h7FFFFFFF, refModel(2'b11, 32'h80000000, 32'h7FFFFFFF), 1'b0);
      idleCycles(1);

      // Flush while in CAP_LO: back to idle, no done, result kept.
      start = 1'b1;
      op    = 2'b01;
      src1  = 32'hDEADBEEF;
      src2  = 32'hCAFEF00D;
      stepCycle();
      start = 1'b0;
      stepCycle();
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      checkOutput("flush_busy", 32'(busy), 32'h0);
      checkOutput("flush_done", 32'(done), 32'h0);
      checkOutput("flush_result", result, lastResult);
      idleCycles(4);

      // Flush beats a simultaneous start.
      start = 1'b1;
      flush = 1'b1;
      stepCycle();
      start = 1'b0;
      flush = 1'b0;
      checkOutput("flush_start_busy", 32'(busy), 32'h0);
      idleCycles(3);

      // Asynchronous reset while in CAP_HI, then a clean op afterwards.
      start = 1'b1;
      op    = 2'b01;
      src1  = 32'hFFFFFFFF;
      src2  = 32'h00000003;
      stepCycle();
      start = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("cap_hi_busy", 32'(busy), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      lastResult = 32'h0;
      stepCycle();
      reset_n = 1'b1;
      stepCycle();
      applyStimulus(2'b01, 32'hFFFFFFFF, 32'h00000003, refModel(2'b01, 32'hFFFFFFFF, 32'h00000003), 1'b0);
      idleCycles(1);

      // Randomized ops with occasional corner operands and back-to-back issue.
      for (int i = 0; i < 60; i++) begin
         rOp = 2'($urandom_range(0, 3));
         rA  = $urandom;
         rB  = $urandom;
         if ($urandom_range(0, 5) == 0) rA = 32'h80000000;
         if ($urandom_range(0, 5) == 0) rB = 32'hFFFFFFFF;
         applyStimulus(rOp, rA, rB, refModel(rOp, rA, rB), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
      end
      idleCycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/nios2_sopc_nios2_0_cpu_mul_seq.md
# nios2_sopc_NIOS2_0_cpu_mul_seq

Multi-cycle multiply sequencer for the Nios II execute path. It drives operands into the three-partial-product multiplier cell and consumes the cell's registered 16x16 partial products. It assembles either the low 32 bits (`mul`) or, using a second cell pass, the high 32 bits (`mulxuu`/`mulxsu`/`mulxss`) of the 64-bit product. It sits between the ALU operand stage and the multiplier cell, and returns a single 32-bit result with a done pulse.

## Interface
Parameters:
- `SKIP_HI`, default 1: 1 = `mul` skips the high pass (latency 3); 0 = every op runs both passes (uniform latency 4).

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  00 `mul`, 01 `mulxuu`, 10 `mulxsu` (A signed, B unsigned), 11 `mulxss`.
- `src1`, `src2`  in  32  operands A and B; latched on accepted start.
- `flush`  in  1  synchronous abort.
- `busy`  out  1  high in any state other than IDLE and DONE.
- `done`  out  1  one-cycle pulse; `result` valid in the same cycle.
- `result`  out  32  product word; held until the next done.
- `cell_src1`, `cell_src2`  out  32  operands to the cell.
- `cell_en`  out  1  cell clock enable.
- `cell_p1`, `cell_p2`, `cell_p3`  in  32  cell outputs. Each is unsigned, registered, and has 1-cycle latency: p1=aL·bL, p2=aL·bH, p3=aH·bL.

## Operation
- States: IDLE, ISSUE_LO, CAP_LO, CAP_HI, DONE.
- IDLE/DONE + `start`: latch A, B, op → ISSUE_LO. Without `start`, DONE → IDLE.
- ISSUE_LO:
  - `cell_src1`=A, `cell_src2`=B, `cell_en`=1.
  - → CAP_LO.
- CAP_LO:
  - Capture `acc` = p1 + ((p2 + p3) << 16), computed in 64 bits; p2+p3 is a 33-bit sum, so no carry is lost.
  - If high pass is needed: drive `cell_src1`={16'h0,A[31:16]}, `cell_src2`={16'h0,B[31:16]}, `cell_en`=1 → CAP_HI.
  - Otherwise (`op`=00 and `SKIP_HI`=1): `result`=acc[31:0] → DONE.
- CAP_HI:
  - hi = acc[63:32] + p1, mod 2^32.
  - Signed correction, mod 2^32: subtract B if op∈{10,11} and A[31]; subtract A if op=11 and B[31].
  - `result` = hi; for `op`=00 with `SKIP_HI`=0, `result` = acc[31:0] instead.
  - → DONE.
- `cell_en`=0 and `cell_src*`=0 in all other states.
- `start` while busy: ignored, no queueing.
- `flush`: → IDLE next cycle from any state, no `done`, `result` unchanged. Flush wins over a simultaneous `start`.
- Operands are latched; `src1`/`src2` may change after acceptance.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `cell_en`=0, `cell_src1`=`cell_src2`=0, `acc`=0.
- `start` accepted in cycle 0 → ISSUE_LO in cycle 1 → CAP_LO in cycle 2.
- `mul` with `SKIP_HI`=1: `done` in cycle 3. Everything else: `done` in cycle 4.
- Back-to-back: `start` during DONE is accepted; the next ISSUE_LO follows immediately, giving throughput of one op per 3 (or 4) cycles.
- Reset asserted mid-op: immediate return to reset values. The cell is cleared by the same reset, so no stale partials survive.
- `done` is registered, never combinational from `start`.

## Configuration
- `NIOS2_MUL_SEQ_SIGNED_EN` defined: signed corrections applied as above.
- Undefined: correction logic is removed; op 10 and 11 behave exactly as 01 (unsigned high word). `op` decoding and latency are unchanged.

## Test plan
- `mul` A=0x00010003, B=0x00020005, `SKIP_HI`=1 → `done` at cycle 3, `result`=0x000B000F. With `SKIP_HI`=0: same value at cycle 4.
- `mulxuu` A=B=0xFFFFFFFF → `done` at cycle 4, `result`=0xFFFFFFFE. `mulxuu` A=0x00010003, B=0x00020005 → 0x00000002.
- `mulxss` A=B=0xFFFFFFFF → 0x00000000 with macro defined; 0xFFFFFFFE without.
- `mulxsu` A=0xFFFFFFFF, B=0x00000002 → 0xFFFFFFFF with macro defined; 0x00000001 without.
- `start` pulsed again in cycles 1–2 → ignored. `start` in the DONE cycle → second result follows 3/4 cycles later, with the first result held in between.
- `flush` in CAP_LO → IDLE next cycle, no `done`, `result` keeps its old value. `reset_n` low in CAP_HI → all outputs 0 asynchronously, and the next op after release completes correctly.
